// File: rtl/apu_cmd_tx.sv
// apu_cmd_tx: host-side command serializer for the APU serial input.
// Buffers {sync, addr, data} write requests in a small FIFO and sends each
// one as two 8N1 bytes ({4'b1000, addr} then data) at BAUDRATE, followed
// by one idle bit time.
// Optional build macro APU_CMD_TX_SYNC_EN: entries flagged with sync are
// held at the FIFO head until a frame_tick has been seen.
module apu_cmd_tx #(
  parameter int CLKRATE    = 1_789_773,
  parameter int BAUDRATE   = 9600,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_sync,
  input  logic       frame_tick,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV   = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0]    DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    DIV_M2  = CNT_W'(DIV - 2);
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        baud_cnt;
  logic [2:0]              bit_idx;
  logic                    second;
  logic [7:0]              shifter;
  logic [11:0]             hold;

  logic [12:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic [12:0]             head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    release_ok;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr];
  assign pop       = (state == S_IDLE) & !empty & release_ok;
  assign busy      = (state != S_IDLE) | !empty;

`ifdef APU_CMD_TX_SYNC_EN
  logic sync_pend;

  assign release_ok = !head[12] | sync_pend;

  // Remember a frame tick until it releases a sync entry; a tick that finds
  // a plain entry at the head discards any earlier one (no accumulation).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pend <= 1'b0;
    end else if (pop & head[12]) begin
      sync_pend <= 1'b0;
    end else if (frame_tick) begin
      if (state != S_IDLE) begin
        sync_pend <= 1'b1;
      end else if (!empty) begin
        sync_pend <= head[12];
      end
    end
  end
`else
  logic unused_sync;

  assign release_ok  = 1'b1;
  assign unused_sync = frame_tick ^ head[12];
`endif

  // FIFO storage; payload is not reset, only pointers and count are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_sync, cmd_addr, cmd_data};
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a request was presented while the FIFO was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (cmd_valid & !cmd_ready) begin
      overflow <= 1'b1;
    end
  end

  // Holding register and byte shifter for the command being transmitted.
  always_ff @(posedge clk) begin
    if (pop) begin
      hold <= head[11:0];
    end
    if (state == S_LOAD) begin
      shifter <= second ? hold[7:0] : {4'b1000, hold[11:8]};
    end
  end

  // Transmit sequencer. The second-pass LOAD cycle is the last cycle of
  // byte A's stop bit, so a full command spans exactly 21 bit periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      second   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            second <= 1'b0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shifter[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (!second && baud_cnt == DIV_M2) begin
            baud_cnt <= '0;
            second   <= 1'b1;
            state    <= S_LOAD;
          end else if (second && baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            state    <= S_GAP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apu_cmd_tx.sv
// tb_apu_cmd_tx: directed, table-driven bench for apu_cmd_tx at default
// parameters (bit period 186 cycles).
`timescale 1ns/1ps
module tb_apu_cmd_tx;

  localparam int DIV = 186;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_sync = 1'b0;
  logic       frame_tick = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  apu_cmd_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_sync   (cmd_sync),
    .frame_tick (frame_tick),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after posedge number n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; presents one request for one posedge.
  task automatic push(input logic [3:0] a, input logic [7:0] d, input logic s, output int p);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_sync  = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_sync  = 1'b0;
    p = cyc;
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n = 0;
    ok = 1'b1;
    b  = '0;
    while (tx !== 1'b0 && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (DIV / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = tx;
    end
    repeat (DIV) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_cmd(input string name, input int idx);
    logic [7:0] a, b;
    logic oka, okb;
    rx_byte(a, oka);
    rx_byte(b, okb);
    chk({name, "_framing"}, {30'd0, oka, okb}, 32'd3);
    chk({name, "_byte_a"}, {24'd0, a}, {24'd0, vecs[idx].exp_a});
    chk({name, "_byte_b"}, {24'd0, b}, {24'd0, vecs[idx].exp_b});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p, p2, t, bad_tx, bad_busy, bad_rdy, bad_ovf;
    logic [19:0] fr;

    vecs[0] = '{4'h3, 8'hA5, 8'h83, 8'hA5};
    vecs[1] = '{4'h0, 8'h00, 8'h80, 8'h00};
    vecs[2] = '{4'hF, 8'hFF, 8'h8F, 8'hFF};
    vecs[3] = '{4'hA, 8'h5A, 8'h8A, 8'h5A};
    vecs[4] = '{4'h7, 8'h3C, 8'h87, 8'h3C};
    vecs[5] = '{4'hC, 8'h81, 8'h8C, 8'h81};

    // Reset values, then a long idle stretch.
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_ovf = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (cmd_ready !== 1'b1) bad_rdy++;
      if (overflow !== 1'b0) bad_ovf++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_ready", bad_rdy, 0);
    chk("idle_overflow", bad_ovf, 0);

    // Single command with exact bit timing.
    push(vecs[0].addr, vecs[0].data, 1'b0, p);
    wait_cyc(p + 1);
    chk("t1_tx_high", {31'd0, tx}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_cyc(p + 2);
    chk("t1_tx_fall", {31'd0, tx}, 32'd0);
    fr = {1'b1, vecs[0].exp_b, 1'b0, 1'b1, vecs[0].exp_a, 1'b0};
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        wait_cyc(p + 1 + 10 * DIV);
        chk("t1_stop_a_end", {31'd0, tx}, 32'd1);
        wait_cyc(p + 2 + 10 * DIV);
        chk("t1_start_b_edge", {31'd0, tx}, 32'd0);
      end
      wait_cyc(p + 2 + i * DIV + DIV / 2);
      chk($sformatf("t1_bit%0d", i), {31'd0, tx}, {31'd0, fr[i]});
    end
    wait_cyc(p + 2 + 20 * DIV + DIV / 2);
    chk("t1_gap_tx", {31'd0, tx}, 32'd1);
    chk("t1_gap_busy", {31'd0, busy}, 32'd1);
    wait_cyc(p + 1 + 21 * DIV);
    chk("t1_busy_last", {31'd0, busy}, 32'd1);
    wait_cyc(p + 2 + 21 * DIV);
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);
    chk("t1_tx_idle", {31'd0, tx}, 32'd1);

    // Table: one command at a time.
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tab%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
      push(vecs[i].addr, vecs[i].data, 1'b0, p);
      rx_cmd($sformatf("tab%0d", i), i);
    end
    drain("tab");

    // Burst: fill FIFO behind an active command, overflow, then hold.
    fork
      begin
        int n;
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("burst%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
          push(vecs[i].addr, vecs[i].data, 1'b0, p);
        end
        chk("burst_full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("burst_no_ovf_yet", {31'd0, overflow}, 32'd0);
        cmd_addr  = vecs[5].addr;
        cmd_data  = vecs[5].data;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("burst_overflow", {31'd0, overflow}, 32'd1);
        chk("burst_still_full", {31'd0, cmd_ready}, 32'd0);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 25 * DIV) begin
          @(negedge clk);
          n++;
        end
        chk("burst_hold_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("burst_full_again", {31'd0, cmd_ready}, 32'd0);
        chk("burst_ovf_sticky", {31'd0, overflow}, 32'd1);
      end
      begin
        for (int i = 0; i < 6; i++) rx_cmd($sformatf("burst%0d", i), i);
      end
    join
    drain("burst");

    // Async reset in the middle of byte B's data bits with a queued entry.
    push(vecs[1].addr, vecs[1].data, 1'b0, p);
    push(vecs[2].addr, vecs[2].data, 1'b0, p2);
    wait_cyc(p + 2 + 14 * DIV + DIV / 2);
    chk("rst_mid_tx_low", {31'd0, tx}, 32'd0);
    chk("rst_mid_queued", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_async_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad_tx++;
    end
    chk("rst_after_quiet", bad_tx, 0);
    push(vecs[3].addr, vecs[3].data, 1'b0, p);
    wait_cyc(p + 1);
    chk("rst_new_tx_high", {31'd0, tx}, 32'd1);
    wait_cyc(p + 2);
    chk("rst_new_tx_fall", {31'd0, tx}, 32'd0);
    rx_cmd("rst_new", 3);
    drain("rst_new");

    // Sync-flagged command.
    push(vecs[4].addr, vecs[4].data, 1'b1, p);
`ifdef APU_CMD_TX_SYNC_EN
    bad_tx = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
    end
    chk("sync_wait_tx", bad_tx, 0);
    chk("sync_wait_busy", {31'd0, busy}, 32'd1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    t = cyc;
    wait_cyc(t + 1);
    chk("sync_tick_tx_high", {31'd0, tx}, 32'd1);
    wait_cyc(t + 2);
    chk("sync_tick_tx_fall", {31'd0, tx}, 32'd0);
`else
    t = p;
    wait_cyc(t + 1);
    chk("sync_off_tx_high", {31'd0, tx}, 32'd1);
    wait_cyc(t + 2);
    chk("sync_off_tx_fall", {31'd0, tx}, 32'd0);
`endif
    rx_cmd("sync", 4);
    drain("sync");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
